reg_operand_fetch: RTL and testbench
====================================

REG_OPERAND_FETCH -- requirements
Module: reg_operand_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: maximum cycles to wait for regComplete before aborting a read.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: fetch request from decode.
REQ-005 SHALL have port req_ready, output, 1: module accepts a request this cycle.
REQ-006 SHALL have ports req_rs1 and req_rs2, input, 5 each: source register indices.
REQ-007 SHALL have port req_two, input, 1: 1 = fetch both operands; 0 = fetch rs1 only.
REQ-008 SHALL have ports selRS1 and selRS2, output, 5 each: register-file read selects.
REQ-009 SHALL have port reg_select, output, 1: register-file read mode (latched req_two).
REQ-010 SHALL have port read_en, output, 1: register-file read enable.
REQ-011 SHALL have port regComplete, input, 1: register-file read done.
REQ-012 SHALL have ports data_out1 and data_out2, input, 32 each: register-file read data.
REQ-013 SHALL have ports wb_valid (input, 1), wb_rd (input, 5) and wb_data (input, 32): same-cycle write-back for bypass.
REQ-014 SHALL have port op_valid, output, 1: operands are valid.
REQ-015 SHALL have port op_ready, input, 1: consumer accepts the operands.
REQ-016 SHALL have ports op_a and op_b, output, 32 each: fetched operands.
REQ-017 SHALL have port op_err, output, 1: read timed out; qualified by op_valid.

Function
REQ-018 SHALL implement FSM states IDLE, READ, HOLD.
REQ-019 IDLE: req_ready=1; on req_valid SHALL latch rs1, rs2 and two, then enter READ, or enter HOLD directly when no nonzero index needs a read (rs1=0 and either two=0 or rs2=0).
REQ-020 READ: read_en=1, selRS1/selRS2/reg_select SHALL be driven from latched values and held stable; req_ready=0.
REQ-021 READ: the cycle regComplete=1, SHALL capture operands and enter HOLD.
REQ-022 Capture: op_a=data_out1, op_b=(two ? data_out2 : 0).
REQ-023 Index 0 SHALL always yield 0, ignoring the register-file data and bypass.
REQ-024 Bypass: at capture, if wb_valid=1 and wb_rd equals a latched nonzero index, that operand SHALL take wb_data; this applies to rs1 and rs2 independently.
REQ-025 Timeout: a 4-bit counter clears on READ entry and increments each READ cycle without regComplete; when the count equals TIMEOUT_CYC, the FSM SHALL enter HOLD with op_a=op_b=0 and op_err=1.
REQ-026 regComplete in the same cycle as the timeout condition SHALL win: normal capture, op_err=0.
REQ-027 HOLD: op_valid=1, with op_a/op_b/op_err stable; on op_ready=1, SHALL enter IDLE.
REQ-028 op_ready=1 in HOLD SHALL NOT accept a new request in the same cycle; req_ready asserts the next cycle.
REQ-029 Latency: request accepted in cycle N; read_en first high in N+1; regComplete in N+k gives op_valid in N+k+1.
REQ-030 Skip-read latency: op_valid in N+1.
REQ-031 regComplete while not in READ SHALL be ignored.
REQ-032 read_en SHALL be 0 in IDLE and HOLD.

Reset
REQ-033 reset=0 SHALL asynchronously force: state IDLE, req_ready=1, read_en=0, op_valid=0, op_err=0, op_a=op_b=0, selRS1=selRS2=0, reg_select=0, counter=0.
REQ-034 Reset asserted mid-READ or mid-HOLD SHALL abandon the transaction with no output.

Structure
REQ-035 Shared package rf_pkg SHALL hold XLEN=32, REGIDX_W=5 and the fetch-state enum (IDLE, READ, HOLD).
REQ-036 The timeout counter SHALL be a sub-module rf_timeout_cnt (clear, enable, hit output).
REQ-037 All other logic SHALL stay in one module.

Verification
REQ-038 rs1=3, rs2=7, two=1, reg3=0x11, reg7=0x22, regComplete 2 cycles after read_en -> op_a=0x11, op_b=0x22, op_err=0, op_valid at N+3.
REQ-039 rs1=5, two=0, with wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF at capture -> op_a=0xDEADBEEF, op_b=0.
REQ-040 rs1=0, rs2=0, two=1 -> no read_en; op_valid at N+1; op_a=op_b=0.
REQ-041 regComplete never asserted, TIMEOUT_CYC=15 -> HOLD entered after 15 READ cycles with op_err=1 and op_a=op_b=0.
REQ-042 op_ready=0 for 4 cycles in HOLD -> outputs stable, req_ready=0; op_ready=1 -> IDLE next cycle.
REQ-043 reset=0 mid-READ -> all outputs at reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and widths for the register operand fetch unit.
// Imported by the fetch FSM and its timeout counter.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int REGIDX_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/rf_timeout_cnt.sv
// Read-timeout counter: clears on READ entry, counts stalled READ cycles.
// hit_o flags the stalled cycle whose increment would reach LIMIT.
module rf_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the LIMIT-th stalled READ cycle, so read_en lasts LIMIT cycles.
  assign hit_o = en_i && ((cnt_q + 4'd1) == 4'(LIMIT));

endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch: latches source indices, reads the register file,
// applies write-back bypass and presents operands with a timeout error.
module reg_operand_fetch
  import rf_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REGIDX_W-1:0] req_rs1,
  input  logic [REGIDX_W-1:0] req_rs2,
  input  logic                req_two,
  output logic [REGIDX_W-1:0] selRS1,
  output logic [REGIDX_W-1:0] selRS2,
  output logic                reg_select,
  output logic                read_en,
  input  logic                regComplete,
  input  logic [XLEN-1:0]     data_out1,
  input  logic [XLEN-1:0]     data_out2,
  input  logic                wb_valid,
  input  logic [REGIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [XLEN-1:0]     op_a,
  output logic [XLEN-1:0]     op_b,
  output logic                op_err
);

  fetch_state_e        state_q, state_d;
  logic [REGIDX_W-1:0] rs1_q, rs1_d;
  logic [REGIDX_W-1:0] rs2_q, rs2_d;
  logic                two_q, two_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                err_q, err_d;

  logic                skip;
  logic                to_clr;
  logic                to_en;
  logic                to_hit;
  logic [XLEN-1:0]     a_cap;
  logic [XLEN-1:0]     b_cap;

  assign skip   = (req_rs1 == '0) && (!req_two || (req_rs2 == '0));
  assign to_clr = (state_q == IDLE) && req_valid && !skip;
  assign to_en  = (state_q == READ) && !regComplete;

  rf_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (to_clr),
    .en_i  (to_en),
    .hit_o (to_hit)
  );

  // Index 0 overrides both bypass and register-file data.
  always_comb begin
    a_cap = data_out1;
    if (wb_valid && (wb_rd == rs1_q)) a_cap = wb_data;
    if (rs1_q == '0) a_cap = '0;
    b_cap = data_out2;
    if (wb_valid && (wb_rd == rs2_q)) b_cap = wb_data;
    if (!two_q || (rs2_q == '0)) b_cap = '0;
  end

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    two_d   = two_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          two_d = req_two;
          if (skip) begin
            a_d     = '0;
            b_d     = '0;
            err_d   = 1'b0;
            state_d = HOLD;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (regComplete) begin
          a_d     = a_cap;
          b_d     = b_cap;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (to_hit) begin
          a_d     = '0;
          b_d     = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      two_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      two_q   <= two_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign read_en    = (state_q == READ);
  assign op_valid   = (state_q == HOLD);
  assign selRS1     = rs1_q;
  assign selRS2     = rs2_q;
  assign reg_select = two_q;
  assign op_a       = a_q;
  assign op_b       = b_q;
  assign op_err     = err_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Bench for reg_operand_fetch: vector table, random transactions
// against a rule-level model, and reset corner cases.
module tb_reg_operand_fetch;

  localparam int TMO = 15;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        req_two;
  logic [4:0]  selRS1;
  logic [4:0]  selRS2;
  logic        reg_select;
  logic        read_en;
  logic        regComplete;
  logic [31:0] data_out1;
  logic [31:0] data_out2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_err;

  reg_operand_fetch #(
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_two     (req_two),
    .selRS1      (selRS1),
    .selRS2      (selRS2),
    .reg_select  (reg_select),
    .read_en     (read_en),
    .regComplete (regComplete),
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_err      (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passed = 0;
  logic [31:0] regs [32];

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        two;
    int          k;
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ee;
    int          el;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Expected result straight from the fetch rules.
  task automatic model(input logic [4:0] r1, input logic [4:0] r2,
                       input logic tw, input int k, input logic wv,
                       input logic [4:0] wr, input logic [31:0] wd,
                       output logic [31:0] ea, output logic [31:0] eb,
                       output logic ee, output int el);
    ee = 1'b0;
    if (r1 == 0 && (!tw || r2 == 0)) begin
      ea = 0; eb = 0; el = 1;
    end else if (k > TMO) begin
      ea = 0; eb = 0; ee = 1'b1; el = TMO + 1;
    end else begin
      el = k + 1;
      if (r1 == 0) ea = 0;
      else if (wv && wr == r1) ea = wd;
      else ea = regs[r1];
      if (!tw || r2 == 0) eb = 0;
      else if (wv && wr == r2) eb = wd;
      else eb = regs[r2];
    end
  endtask

  task automatic noise();
    regComplete = 1'($urandom);
    data_out1   = $urandom;
    data_out2   = $urandom;
    wb_valid    = 1'($urandom);
    wb_rd       = 5'($urandom);
    wb_data     = $urandom;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ctl"},
        {27'd0, req_ready, read_en, op_valid, op_err, reg_select},
        32'b10000);
    chk({tag, ".sel"}, {22'd0, selRS1, selRS2}, 32'd0);
    chk({tag, ".op_a"}, op_a, 32'd0);
    chk({tag, ".op_b"}, op_b, 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic txn(input logic [4:0] r1, input logic [4:0] r2,
                     input logic tw, input int k, input logic wv,
                     input logic [4:0] wr, input logic [31:0] wd,
                     input int hold, input logic [31:0] ea,
                     input logic [31:0] eb, input logic ee,
                     input int el, input string tag);
    int c;
    int ren;
    logic sel_ok;
    logic stab;
    logic done;
    logic [31:0] ca;
    logic [31:0] cb;
    logic ce;
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_rs1 = r1;
    req_rs2 = r2;
    req_two = tw;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1 = 5'($urandom);
    req_rs2 = 5'($urandom);
    req_two = 1'($urandom);
    c = 1;
    ren = 0;
    sel_ok = 1'b1;
    done = 1'b0;
    while (!done && c < 40) begin
      noise();
      regComplete = 1'b0;
      if (op_valid) begin
        done = 1'b1;
      end else begin
        if (read_en) begin
          ren++;
          if (selRS1 !== r1 || selRS2 !== r2 || reg_select !== tw)
            sel_ok = 1'b0;
          if (ren == k) begin
            regComplete = 1'b1;
            data_out1 = regs[selRS1];
            data_out2 = regs[selRS2];
            wb_valid = wv;
            wb_rd = wr;
            wb_data = wd;
          end
        end
        @(posedge clk);
        @(negedge clk);
        c++;
      end
    end
    chk({tag, ".latency"}, c, el);
    chk({tag, ".read_cycles"}, ren, el - 1);
    chk({tag, ".sel_stable"}, {31'd0, sel_ok}, 32'd1);
    chk({tag, ".op_valid"}, {31'd0, op_valid}, 32'd1);
    chk({tag, ".op_a"}, op_a, ea);
    chk({tag, ".op_b"}, op_b, eb);
    chk({tag, ".op_err"}, {31'd0, op_err}, {31'd0, ee});
    ca = op_a;
    cb = op_b;
    ce = op_err;
    stab = 1'b1;
    for (int i = 0; i < hold; i++) begin
      noise();
      op_ready = 1'b0;
      req_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (!op_valid || op_a !== ca || op_b !== cb || op_err !== ce ||
          req_ready || read_en)
        stab = 1'b0;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, {31'd0, stab}, 32'd1);
    noise();
    op_ready = 1'b1;
    req_valid = 1'b1;
    req_rs1 = 5'd9;
    req_two = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op_ready = 1'b0;
    req_valid = 1'b0;
    regComplete = 1'b0;
    chk({tag, ".release"},
        {29'd0, req_ready, op_valid, read_en}, 32'b100);
  endtask

  initial begin
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ee;
    int          el;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        tw;
    int          k;
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;

    reset = 1'b0;
    req_valid = 1'b0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_two = 1'b0;
    op_ready = 1'b0;
    regComplete = 1'b0;
    data_out1 = '0;
    data_out2 = '0;
    wb_valid = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[3] = 32'h11;
    regs[7] = 32'h22;

    vt[0]  = '{5'd3, 5'd7, 1'b1, 2, 1'b0, 5'd0, 32'h0, 4,
               32'h11, 32'h22, 1'b0, 3};
    vt[1]  = '{5'd5, 5'd0, 1'b0, 1, 1'b1, 5'd5, 32'hDEADBEEF, 1,
               32'hDEADBEEF, 32'h0, 1'b0, 2};
    vt[2]  = '{5'd0, 5'd0, 1'b1, 1, 1'b0, 5'd0, 32'h0, 1,
               32'h0, 32'h0, 1'b0, 1};
    vt[3]  = '{5'd0, 5'd9, 1'b0, 1, 1'b0, 5'd0, 32'h0, 0,
               32'h0, 32'h0, 1'b0, 1};
    vt[4]  = '{5'd0, 5'd9, 1'b1, 1, 1'b1, 5'd0, 32'hFFFF0000, 0,
               32'h0, 32'h1000_0009, 1'b0, 2};
    vt[5]  = '{5'd4, 5'd4, 1'b1, 3, 1'b1, 5'd4, 32'hCAFEF00D, 2,
               32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4};
    vt[6]  = '{5'd6, 5'd8, 1'b1, 2, 1'b1, 5'd0, 32'hFFFFFFFF, 1,
               32'h1000_0006, 32'h1000_0008, 1'b0, 3};
    vt[7]  = '{5'd10, 5'd12, 1'b1, 1, 1'b1, 5'd12, 32'hAAAA5555, 0,
               32'h1000_000A, 32'hAAAA5555, 1'b0, 2};
    vt[8]  = '{5'd2, 5'd3, 1'b1, 99, 1'b0, 5'd0, 32'h0, 2,
               32'h0, 32'h0, 1'b1, 16};
    vt[9]  = '{5'd2, 5'd3, 1'b1, 15, 1'b0, 5'd0, 32'h0, 1,
               32'h1000_0002, 32'h11, 1'b0, 16};
    vt[10] = '{5'd1, 5'd0, 1'b1, 1, 1'b0, 5'd0, 32'h0, 0,
               32'h1000_0001, 32'h0, 1'b0, 2};

    repeat (2) @(negedge clk);
    chk_reset("por");
    reset = 1'b1;
    @(negedge clk);
    chk_reset("por_idle");

    for (int i = 0; i < 11; i++) begin
      txn(vt[i].rs1, vt[i].rs2, vt[i].two, vt[i].k, vt[i].wv,
          vt[i].wr, vt[i].wd, vt[i].hold, vt[i].ea, vt[i].eb,
          vt[i].ee, vt[i].el, $sformatf("vec%0d", i));
    end

    // Abandon a read in flight: outputs clear before any clock edge.
    req_valid = 1'b1;
    req_rs1 = 5'd3;
    req_two = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midread.read_en", {31'd0, read_en}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk_reset("midread");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("midread_after");

    // Abandon a held result.
    req_valid = 1'b1;
    req_rs1 = 5'd7;
    req_two = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    regComplete = 1'b1;
    data_out1 = regs[7];
    wb_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    regComplete = 1'b0;
    chk("midhold.op_a", op_a, 32'h22);
    #1 reset = 1'b0;
    #1 chk_reset("midhold");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int n = 0; n < 40; n++) begin
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      tw = 1'($urandom);
      k = $urandom_range(1, 17);
      wv = 1'($urandom);
      case ($urandom_range(0, 2))
        0: wr = r1;
        1: wr = r2;
        default: wr = 5'($urandom);
      endcase
      wd = $urandom;
      model(r1, r2, tw, k, wv, wr, wd, ea, eb, ee, el);
      txn(r1, r2, tw, k, wv, wr, wd, $urandom_range(0, 2),
          ea, eb, ee, el, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
